// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR file: CSR addresses, the CSR
// operation encoding and the bit positions of the WARL fields in mstatus,
// mie and mip.
// Ports: none (package).
// -----------------------------------------------------------------------------
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MIP_MEIP_BIT     = 11;

  // Address space encoding: addr[11:10]==2'b11 marks a read-only CSR.
  // mip lives in the RW range but its bits are driven by hardware only.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr[11:10] == 2'b11) || (addr == CSR_MIP);
  endfunction

endpackage

// File: rtl/csr_file_counter.sv
// -----------------------------------------------------------------------------
// csr_counter
// CNT_WIDTH-bit event counter split into a low XLEN half and a high half.
// A write to one half replaces that half and holds the other one for the
// cycle (no increment, no carry); otherwise the counter adds inc_i with
// full carry and wraps silently.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   inc_i         add one this cycle
//   wr_lo_i       load low half from wdata_i
//   wr_hi_i       load high half from wdata_i
//   wdata_i       write data
//   cnt_o         current counter value
// -----------------------------------------------------------------------------
module csr_counter #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 wr_lo_i,
  input  logic                 wr_hi_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  localparam int HI_W = CNT_WIDTH - XLEN;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc_s;

  // Next counter value: half write wins over the increment.
  always_comb begin
    cnt_inc_s = cnt_q + CNT_WIDTH'(inc_i);
    cnt_d     = cnt_inc_s;
    if (wr_lo_i) begin
      cnt_d = {cnt_q[CNT_WIDTH-1:XLEN], wdata_i};
    end else if (wr_hi_i) begin
      cnt_d = {wdata_i[HI_W-1:0], cnt_q[XLEN-1:0]};
    end else begin
      cnt_d = cnt_inc_s;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
// Machine-mode CSR file: atomic RW/RS/RC access, 64-bit mcycle/minstret,
// trap entry / mret state update and interrupt-take qualification.
// Reads are combinational; every state update happens on the rising edge.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   csr_en_i, csr_op_i    CSR access this cycle and its operation
//   csr_addr_i            CSR address
//   csr_wdata_i           rs1 value / zero-extended uimm
//   csr_src_zero_i        source is x0 / uimm 0 (RS/RC do not write)
//   csr_rdata_o           old CSR value (0 on illegal access)
//   csr_illegal_o         unknown address or write to a read-only CSR
//   instret_inc_i         one instruction retired
//   trap_valid_i, trap_cause_i, trap_pc_i   trap entry
//   mret_i                mret retiring
//   irq_ext_i, irq_timer_i  interrupt levels
//   irq_take_o            enabled interrupt pending with MIE set
//   mtvec_out_o, mepc_out_o  trap vector and return PC
// -----------------------------------------------------------------------------
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              CNT_WIDTH = 64,
  parameter int              HART_ID   = 0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csr_en_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            csr_src_zero_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            instret_inc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  output logic            irq_take_o,
  output logic [XLEN-1:0] mtvec_out_o,
  output logic [XLEN-1:0] mepc_out_o
);

  localparam int HI_W = CNT_WIDTH - XLEN;

  csr_op_e op_s;
  logic [XLEN-1:0] old_s, new_s;
  logic known_s, ro_s, op_active_s, wr_attempt_s, illegal_s, csr_we_s;
  logic [CNT_WIDTH-1:0] mcycle_s, minstret_s;

  logic mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic mie_meie_q, mie_meie_d, mie_mtie_q, mie_mtie_d;
  logic mip_meip_q, mip_meip_d, mip_mtip_q, mip_mtip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;

  assign op_s = csr_op_e'(csr_op_i);

  // Read mux: WARL view of every implemented CSR, unknown addresses read 0.
  always_comb begin
    old_s   = {XLEN{1'b0}};
    known_s = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        old_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        old_s[MSTATUS_MPIE_BIT]              = mstatus_mpie_q;
        old_s[MSTATUS_MIE_BIT]               = mstatus_mie_q;
      end
      CSR_MIE: begin
        old_s[MIE_MEIE_BIT] = mie_meie_q;
        old_s[MIE_MTIE_BIT] = mie_mtie_q;
      end
      CSR_MIP: begin
        old_s[MIP_MEIP_BIT] = mip_meip_q;
        old_s[MIP_MTIP_BIT] = mip_mtip_q;
      end
      CSR_MTVEC:                old_s = {mtvec_q[XLEN-1:2], 2'b00};
      CSR_MSCRATCH:             old_s = mscratch_q;
      CSR_MEPC:                 old_s = {mepc_q[XLEN-1:2], 2'b00};
      CSR_MCAUSE:               old_s = mcause_q;
      CSR_MCYCLE, CSR_CYCLE:    old_s = mcycle_s[XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH:  old_s[HI_W-1:0] = mcycle_s[CNT_WIDTH-1:XLEN];
      CSR_MINSTRET, CSR_INSTRET: old_s = minstret_s[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_s[HI_W-1:0] = minstret_s[CNT_WIDTH-1:XLEN];
      CSR_MHARTID:              old_s = XLEN'(HART_ID);
      default:                  known_s = 1'b0;
    endcase
  end

  assign ro_s         = csr_is_ro(csr_addr_i);
  assign op_active_s  = csr_en_i & (op_s != CSR_OP_NONE);
  // RS/RC from x0 (or uimm 0) is a pure read, so it is legal on RO CSRs.
  assign wr_attempt_s = (op_s == CSR_OP_RW) | ~csr_src_zero_i;
  assign illegal_s    = op_active_s & (~known_s | (ro_s & wr_attempt_s));
  // Trap and mret take precedence over a same-cycle CSR write.
  assign csr_we_s     = op_active_s & wr_attempt_s & ~illegal_s & ~trap_valid_i & ~mret_i;

  // Read-modify-write data.
  always_comb begin
    case (op_s)
      CSR_OP_RW: new_s = csr_wdata_i;
      CSR_OP_RS: new_s = old_s | csr_wdata_i;
      CSR_OP_RC: new_s = old_s & ~csr_wdata_i;
      default:   new_s = old_s;
    endcase
  end

  // Next-state for the architectural registers: trap > mret > CSR write.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mie_mtie_d     = mie_mtie_q;
    mip_meip_d     = irq_ext_i;
    mip_mtip_d     = irq_timer_i;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    if (trap_valid_i) begin
      mepc_d         = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d       = trap_cause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we_s) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = new_s[MSTATUS_MIE_BIT];
          mstatus_mpie_d = new_s[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mie_meie_d = new_s[MIE_MEIE_BIT];
          mie_mtie_d = new_s[MIE_MTIE_BIT];
        end
        CSR_MTVEC:    mtvec_d    = {new_s[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = new_s;
        CSR_MEPC:     mepc_d     = {new_s[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = new_s;
        default:      mcause_d   = mcause_q;
      endcase
    end else begin
      mcause_d = mcause_q;
    end
  end

  // Architectural register bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mip_meip_q     <= 1'b0;
      mip_mtip_q     <= 1'b0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= {XLEN{1'b0}};
      mepc_q         <= {XLEN{1'b0}};
      mcause_q       <= {XLEN{1'b0}};
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mie_mtie_q     <= mie_mtie_d;
      mip_meip_q     <= mip_meip_d;
      mip_mtip_q     <= mip_mtip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

  csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we_s & (csr_addr_i == CSR_MCYCLE)),
    .wr_hi_i (csr_we_s & (csr_addr_i == CSR_MCYCLEH)),
    .wdata_i (new_s),
    .cnt_o   (mcycle_s)
  );

  csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instret_inc_i),
    .wr_lo_i (csr_we_s & (csr_addr_i == CSR_MINSTRET)),
    .wr_hi_i (csr_we_s & (csr_addr_i == CSR_MINSTRETH)),
    .wdata_i (new_s),
    .cnt_o   (minstret_s)
  );

  assign csr_rdata_o   = illegal_s ? {XLEN{1'b0}} : old_s;
  assign csr_illegal_o = illegal_s;
  assign irq_take_o    = mstatus_mie_q & ((mie_meie_q & mip_meip_q) | (mie_mtie_q & mip_mtip_q));
  assign mtvec_out_o   = {mtvec_q[XLEN-1:2], 2'b00};
  assign mepc_out_o    = {mepc_q[XLEN-1:2], 2'b00};

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

  localparam logic [31:0] MTVEC_RST_P = 32'h8000_0101;
  localparam int          HART_P      = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, csr_en, csr_src_zero, instret_inc, trap_valid, mret, irq_ext, irq_timer;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, trap_cause, trap_pc;
  logic [31:0] csr_rdata, mtvec_out, mepc_out;
  logic        csr_illegal, irq_take;

  csr_file #(.XLEN(32), .CNT_WIDTH(64), .HART_ID(HART_P), .MTVEC_RST(MTVEC_RST_P)) dut (
    .clk_i(clk), .rst_i(rst), .csr_en_i(csr_en), .csr_op_i(csr_op), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_src_zero_i(csr_src_zero), .csr_rdata_o(csr_rdata),
    .csr_illegal_o(csr_illegal), .instret_inc_i(instret_inc), .trap_valid_i(trap_valid),
    .trap_cause_i(trap_cause), .trap_pc_i(trap_pc), .mret_i(mret), .irq_ext_i(irq_ext),
    .irq_timer_i(irq_timer), .irq_take_o(irq_take), .mtvec_out_o(mtvec_out), .mepc_out_o(mepc_out)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        illegal;
    logic        irq_take;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_bad = 0;

  // stimulus for the next cycle
  bit        s_rst, s_en, s_sz, s_inc, s_trap, s_mret, s_ext, s_tim, s_chk;
  bit [1:0]  s_op;
  bit [11:0] s_addr;
  bit [31:0] s_wdata, s_tcause, s_tpc, s_chk_val;

  // reference model state (architectural view)
  bit        m_valid = 1'b0;
  bit        m_mie, m_mpie, m_meip, m_mtip;
  bit [31:0] m_miereg, m_mtvec, m_mscratch, m_mepc, m_mcause;
  bit [63:0] m_cycle, m_instret;

  function automatic void model_read(input bit [11:0] a, output bit known, output bit ro,
                                     output bit [31:0] v);
    known = 1'b1; ro = 1'b0; v = 32'h0;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: v = m_miereg;
      12'h305: v = m_mtvec & ~32'h3;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: begin ro = 1'b1; v = (32'(m_meip) << 11) | (32'(m_mtip) << 7); end
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
      12'hC00: begin ro = 1'b1; v = m_cycle[31:0]; end
      12'hC80: begin ro = 1'b1; v = m_cycle[63:32]; end
      12'hC02: begin ro = 1'b1; v = m_instret[31:0]; end
      12'hC82: begin ro = 1'b1; v = m_instret[63:32]; end
      12'hF14: begin ro = 1'b1; v = 32'(HART_P); end
      default: known = 1'b0;
    endcase
  endfunction

  // Apply one cycle of stimulus, queue the expected response, advance the model.
  task automatic step();
    bit known, ro, act, attempt, ill, we;
    bit [31:0] oldv, newv;
    bit [63:0] n_cycle, n_instret;
    exp_t e;
    @(posedge clk);
    #2;
    rst = s_rst; csr_en = s_en; csr_op = s_op; csr_addr = s_addr; csr_wdata = s_wdata;
    csr_src_zero = s_sz; instret_inc = s_inc; trap_valid = s_trap; trap_cause = s_tcause;
    trap_pc = s_tpc; mret = s_mret; irq_ext = s_ext; irq_timer = s_tim;

    model_read(s_addr, known, ro, oldv);
    act     = s_en && (s_op != 2'd0);
    attempt = (s_op == 2'd1) || !s_sz;
    ill     = act && (!known || (ro && attempt));
    newv    = (s_op == 2'd1) ? s_wdata : (s_op == 2'd2) ? (oldv | s_wdata) : (oldv & ~s_wdata);
    we      = act && attempt && !ill && !s_trap && !s_mret;

    if (m_valid) begin
      e.rdata    = s_chk ? s_chk_val : (ill ? 32'h0 : oldv);
      e.illegal  = ill;
      e.irq_take = m_mie && ((m_miereg[11] && m_meip) || (m_miereg[7] && m_mtip));
      e.mtvec    = m_mtvec & ~32'h3;
      e.mepc     = m_mepc;
      exp_q.push_back(e);
    end

    n_cycle   = m_cycle + 64'd1;
    n_instret = m_instret + 64'(s_inc);
    if (we) begin
      case (s_addr)
        12'hB00: n_cycle   = {m_cycle[63:32], newv};
        12'hB80: n_cycle   = {newv, m_cycle[31:0]};
        12'hB02: n_instret = {m_instret[63:32], newv};
        12'hB82: n_instret = {newv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle = n_cycle; m_instret = n_instret;
    m_meip = s_ext; m_mtip = s_tim;
    if (s_trap) begin
      m_mepc = s_tpc & ~32'h3; m_mcause = s_tcause; m_mpie = m_mie; m_mie = 1'b0;
    end else if (s_mret) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (we) begin
      case (s_addr)
        12'h300: begin m_mie = newv[3]; m_mpie = newv[7]; end
        12'h304: m_miereg = newv & 32'h0000_0880;
        12'h305: m_mtvec = newv & ~32'h3;
        12'h340: m_mscratch = newv;
        12'h341: m_mepc = newv & ~32'h3;
        12'h342: m_mcause = newv;
        default: ;
      endcase
    end
    if (s_rst) begin
      m_mie = 1'b0; m_mpie = 1'b0; m_meip = 1'b0; m_mtip = 1'b0; m_miereg = 32'h0;
      m_mtvec = MTVEC_RST_P; m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
      m_cycle = 64'h0; m_instret = 64'h0; m_valid = 1'b1;
    end
  endtask

  task automatic idle();
    s_rst = 1'b0; s_en = 1'b0; s_op = 2'd0; s_addr = 12'h0; s_wdata = 32'h0; s_sz = 1'b0;
    s_inc = 1'b0; s_trap = 1'b0; s_mret = 1'b0; s_tcause = 32'h0; s_tpc = 32'h0; s_chk = 1'b0;
    s_chk_val = 32'h0;
  endtask

  task automatic do_csr(input bit [1:0] op, input bit [11:0] a, input bit [31:0] w, input bit sz);
    idle(); s_en = 1'b1; s_op = op; s_addr = a; s_wdata = w; s_sz = sz;
    step();
  endtask

  task automatic rd(input bit [11:0] a, input bit chk, input bit [31:0] v);
    idle(); s_addr = a; s_chk = chk; s_chk_val = v;
    step();
  endtask

  // Monitor: pops one expected response per cycle and compares mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (csr_rdata !== mon_e.rdata) begin
        n_bad++; $display("FAIL rdata addr=%h got=%h exp=%h t=%0t", csr_addr, csr_rdata, mon_e.rdata, $time);
      end
      if (csr_illegal !== mon_e.illegal) begin
        n_bad++; $display("FAIL illegal addr=%h got=%b exp=%b t=%0t", csr_addr, csr_illegal, mon_e.illegal, $time);
      end
      if (irq_take !== mon_e.irq_take) begin
        n_bad++; $display("FAIL irq_take got=%b exp=%b t=%0t", irq_take, mon_e.irq_take, $time);
      end
      if (mtvec_out !== mon_e.mtvec) begin
        n_bad++; $display("FAIL mtvec_out got=%h exp=%h t=%0t", mtvec_out, mon_e.mtvec, $time);
      end
      if (mepc_out !== mon_e.mepc) begin
        n_bad++; $display("FAIL mepc_out got=%h exp=%h t=%0t", mepc_out, mon_e.mepc, $time);
      end
    end
  end

  bit [11:0] addr_tbl [20] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                              12'hC82, 12'hF14, 12'h301, 12'h7C0, 12'hB01, 12'h343};

  initial begin
    idle(); s_ext = 1'b0; s_tim = 1'b0;
    rst = 1'b1; csr_en = 1'b0; csr_op = 2'd0; csr_addr = 12'h0; csr_wdata = 32'h0;
    csr_src_zero = 1'b0; instret_inc = 1'b0; trap_valid = 1'b0; trap_cause = 32'h0;
    trap_pc = 32'h0; mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;

    // reset and reset values
    s_rst = 1'b1; step();
    s_rst = 1'b1; step();
    rd(12'h300, 1'b1, 32'h0000_1800);
    rd(12'h305, 1'b1, 32'h8000_0100);
    rd(12'hF14, 1'b1, 32'(HART_P));

    // RW / RS / RC read-modify-write on mscratch
    do_csr(2'd1, 12'h340, 32'hA5A5_0000, 1'b0);
    do_csr(2'd2, 12'h340, 32'h0000_00FF, 1'b0);
    do_csr(2'd3, 12'h340, 32'hA000_0000, 1'b0);
    rd(12'h340, 1'b1, 32'h05A5_00FF);
    do_csr(2'd2, 12'h340, 32'hFFFF_FFFF, 1'b1);
    do_csr(2'd3, 12'h340, 32'hFFFF_FFFF, 1'b1);
    rd(12'h340, 1'b1, 32'h05A5_00FF);

    // mcycle carry from lo into hi, RO alias write is illegal
    do_csr(2'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    do_csr(2'd1, 12'hB80, 32'h0000_0000, 1'b0);
    rd(12'hB80, 1'b1, 32'h0000_0000);
    rd(12'hB00, 1'b1, 32'h0000_0000);
    rd(12'hB80, 1'b1, 32'h0000_0001);
    do_csr(2'd1, 12'hC00, 32'h1234_5678, 1'b0);
    rd(12'hB80, 1'b1, 32'h0000_0001);
    do_csr(2'd2, 12'hC00, 32'h0, 1'b1);

    // external interrupt path
    do_csr(2'd1, 12'h304, 32'h0000_0800, 1'b0);
    do_csr(2'd2, 12'h300, 32'h0000_0008, 1'b0);
    s_ext = 1'b1;
    rd(12'h344, 1'b0, 32'h0);
    rd(12'h344, 1'b1, 32'h0000_0800);
    rd(12'h300, 1'b1, 32'h0000_1808);

    // trap entry then mret
    idle(); s_trap = 1'b1; s_tcause = 32'h8000_000B; s_tpc = 32'h0000_0102; step();
    s_ext = 1'b0;
    rd(12'h341, 1'b1, 32'h0000_0100);
    rd(12'h342, 1'b1, 32'h8000_000B);
    rd(12'h300, 1'b1, 32'h0000_1880);
    idle(); s_mret = 1'b1; step();
    rd(12'h300, 1'b1, 32'h0000_1888);

    // trap + mret + CSR write in one cycle: only the trap lands
    idle(); s_trap = 1'b1; s_tcause = 32'h0000_0005; s_tpc = 32'h0000_2006; s_mret = 1'b1;
    s_en = 1'b1; s_op = 2'd1; s_addr = 12'h341; s_wdata = 32'hDEAD_0000; step();
    rd(12'h341, 1'b1, 32'h0000_2004);
    rd(12'h300, 1'b1, 32'h0000_1880);

    // reset mid-sequence overrides a same-cycle write
    do_csr(2'd1, 12'h305, 32'h0000_4003, 1'b0);
    idle(); s_rst = 1'b1; s_en = 1'b1; s_op = 2'd1; s_addr = 12'h340; s_wdata = 32'h55; step();
    rd(12'hB00, 1'b1, 32'h0000_0000);
    rd(12'h340, 1'b1, 32'h0000_0000);
    rd(12'h300, 1'b1, 32'h0000_1800);
    rd(12'h305, 1'b1, 32'h8000_0100);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      s_en    = ($urandom_range(0, 1) == 1);
      s_op    = 2'($urandom_range(0, 3));
      s_addr  = addr_tbl[$urandom_range(0, 19)];
      s_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      s_sz    = ($urandom_range(0, 4) == 0);
      if (s_sz) s_wdata = 32'h0;
      s_inc   = ($urandom_range(0, 1) == 1);
      s_trap  = ($urandom_range(0, 29) == 0);
      s_mret  = ($urandom_range(0, 19) == 0);
      s_rst   = ($urandom_range(0, 249) == 0);
      s_tcause = $urandom;
      s_tpc    = $urandom;
      if ($urandom_range(0, 9) == 0) s_ext = ~s_ext;
      if ($urandom_range(0, 9) == 0) s_tim = ~s_tim;
      step();
    end

    idle(); step();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
